commit_sync_ctrl: RTL and testbench
===================================

COMMIT_SYNC_CTRL -- requirements
Module: commit_sync_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of commit and ISA-step counters.
REQ-002 SHALL have parameter MAX_SKEW, default 4, the largest commit lead one pipelined copy may hold before it is stalled; legal range 1..2^(CNT_W-1)-1.
REQ-003 SHALL have parameter DRAIN_TMO, default 16, the maximum number of DRAIN cycles before timeout.
REQ-004 SHALL have port clk  input  1  clock, all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  start request, sampled in IDLE.
REQ-007 SHALL have port commit1  input  1  pipelined copy 1 retired one instruction this cycle.
REQ-008 SHALL have port commit2  input  1  pipelined copy 2 retired one instruction this cycle.
REQ-009 SHALL have port drain_req  input  1  stop issuing and align all copies, sampled in RUN.
REQ-010 SHALL have port stall1  output  1  freeze copy 1 fetch/retire (combinational from registers).
REQ-011 SHALL have port stall2  output  1  freeze copy 2 fetch/retire (combinational from registers).
REQ-012 SHALL have port isa_step  output  1  registered one-cycle enable advancing both ISA copies by one instruction.
REQ-013 SHALL have port state  output  2  FSM state encoding.
REQ-014 SHALL have port deviation  output  1  sticky synchronisation-violation flag.
REQ-015 SHALL have port done  output  1  high exactly while state==DONE.

Function
REQ-016 SHALL implement FSM IDLE=0, RUN=1, DRAIN=2, DONE=3; IDLE->RUN when en; RUN->DRAIN when drain_req; DRAIN->DONE when cnt1==cnt2==isa_cnt or the DRAIN cycle counter reaches DRAIN_TMO; DONE is terminal until rst.
REQ-017 SHALL increment cnt1 (cnt2) by 1 on each cycle commit1 (commit2) is high in RUN or DRAIN; commits in IDLE/DONE are ignored; simultaneous commits increment both counters.
REQ-018 SHALL compute skew = cnt1-cnt2 modulo 2^CNT_W, interpreted signed, so counter wrap-around never produces a false stall.
REQ-019 SHALL drive stall1 in RUN when skew >= MAX_SKEW, and in DRAIN when skew > 0; stall2 symmetrically for -skew; both stalls are 0 in IDLE and DONE.
REQ-020 SHALL never assert stall1 and stall2 in the same cycle.
REQ-021 SHALL assert isa_step for one cycle, one cycle after min(cnt1,cnt2) (wrap-aware) exceeds isa_cnt, incrementing isa_cnt with each pulse; at most one pulse per cycle, so backlog drains one per cycle.
REQ-022 SHALL set deviation when commitN is high in a cycle where stallN is high, or on DRAIN timeout; deviation is cleared only by rst.
REQ-023 SHALL treat |skew| > MAX_SKEW as deviation (stall was ignored).
REQ-024 SHALL keep counting commits and issuing isa_step after deviation is set (flag is observational only).

Reset
REQ-025 SHALL on rst set state=IDLE, cnt1=cnt2=isa_cnt=0, drain counter=0, isa_step=0, deviation=0; stall1=stall2=0, done=0.
REQ-026 SHALL abandon any RUN/DRAIN progress on rst mid-operation; outputs take reset values the following cycle.

Structure
REQ-027 SHALL place the state enum and default parameter values in shared package sync_pkg, reused by the multi-copy top and its assertions.
REQ-028 SHALL instantiate one sub-module commit_counter per pipelined copy (CNT_W-bit, enable, wrap); skew, FSM and ISA stepping remain in commit_sync_ctrl.

Verification
REQ-029 SHALL cover: en=1, commit1 and commit2 high together for 10 cycles -> stall never asserted, 10 isa_step pulses, each lagging by 1 cycle.
REQ-030 SHALL cover: commit1 only for 4 cycles in RUN (MAX_SKEW=4) -> stall1=1 from cycle after 4th commit; commit2 pulse -> stall1 drops same cycle skew=3.
REQ-031 SHALL cover: cnt1=cnt2=254, 4 joint commits (CNT_W=8) -> counters wrap to 2, skew 0, no stall, no deviation.
REQ-032 SHALL cover: skew=+2, drain_req -> stall1=1 in DRAIN, two commit2 -> DONE once isa_cnt catches up, deviation=0.
REQ-033 SHALL cover: commit1 while stall1=1 -> deviation=1 next cycle and stays 1; DRAIN with no commits from lagging copy -> DONE after 16 cycles, deviation=1.
REQ-034 SHALL cover: rst asserted in DRAIN -> next cycle state=IDLE, all counters 0, outputs at reset values.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared definitions for the commit synchroniser: FSM encoding and default sizing.
package sync_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DEF_CNT_W     = 8;
   localparam int DEF_MAX_SKEW  = 4;
   localparam int DEF_DRAIN_TMO = 16;

   // Commits are only accounted while the copies are actually executing.
   function automatic logic is_counting(input state_e s);
      return (s == ST_RUN) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/commit_counter.sv
// Wrapping retirement counter for one pipelined copy.
module commit_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (en && inc) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/commit_sync_ctrl.sv
// Keeps two pipelined copies and the ISA reference in lock-step: stalls the
// leading copy, paces ISA steps one per cycle and records sync violations.
module commit_sync_ctrl
   import sync_pkg::*;
#(
   parameter int CNT_W     = DEF_CNT_W,
   parameter int MAX_SKEW  = DEF_MAX_SKEW,
   parameter int DRAIN_TMO = DEF_DRAIN_TMO
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       commit1,
   input  logic       commit2,
   input  logic       drain_req,
   output logic       stall1,
   output logic       stall2,
   output logic       isa_step,
   output logic [1:0] state,
   output logic       deviation,
   output logic       done
);

   localparam int DRAIN_W = $clog2(DRAIN_TMO + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TMO - 1);
   localparam logic signed [CNT_W:0] MAX_S  = (CNT_W + 1)'(MAX_SKEW);
   localparam logic signed [CNT_W:0] ZERO_S = '0;

   state_e state_q, state_d;
   logic [CNT_W-1:0]   isa_cnt_q, isa_cnt_d;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
   logic               isa_step_q, isa_step_d;
   logic               deviation_q, deviation_d;

   logic [CNT_W-1:0]   cnt1, cnt2;
   logic [CNT_W-1:0]   diff;
   logic signed [CNT_W:0] skew, neg_skew;
   logic [CNT_W-1:0]   min_cnt, isa_lead;
   logic counting, step_due, aligned, timeout, over_skew;
   logic stall1_c, stall2_c;

   assign counting = is_counting(state_q);

   commit_counter #(.CNT_W(CNT_W)) u_cnt1 (
      .clk   (clk),
      .rst   (rst),
      .en    (counting),
      .inc   (commit1),
      .count (cnt1)
   );

   commit_counter #(.CNT_W(CNT_W)) u_cnt2 (
      .clk   (clk),
      .rst   (rst),
      .en    (counting),
      .inc   (commit2),
      .count (cnt2)
   );

   // Modular difference, sign-extended by one bit so negation never overflows.
   assign diff     = cnt1 - cnt2;
   assign skew     = {diff[CNT_W-1], diff};
   assign neg_skew = -skew;

   assign min_cnt  = diff[CNT_W-1] ? cnt1 : cnt2;
   assign isa_lead = min_cnt - isa_cnt_q;
   assign step_due = (isa_lead != '0) && !isa_lead[CNT_W-1];

   assign aligned   = (cnt1 == cnt2) && (cnt2 == isa_cnt_q);
   assign timeout   = (state_q == ST_DRAIN) && !aligned && (drain_cnt_q == DRAIN_LAST);
   assign over_skew = (skew > MAX_S) || (neg_skew > MAX_S);

   always_comb begin
      stall1_c = 1'b0;
      stall2_c = 1'b0;
      case (state_q)
         ST_RUN: begin
            stall1_c = (skew >= MAX_S);
            stall2_c = (neg_skew >= MAX_S);
         end
         ST_DRAIN: begin
            stall1_c = (skew > ZERO_S);
            stall2_c = (neg_skew > ZERO_S);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      isa_step_d  = step_due;
      isa_cnt_d   = isa_cnt_q + CNT_W'(step_due);
      deviation_d = deviation_q | (commit1 & stall1_c) | (commit2 & stall2_c)
                    | over_skew | timeout;
      case (state_q)
         ST_IDLE:  if (en) state_d = ST_RUN;
         ST_RUN:   if (drain_req) state_d = ST_DRAIN;
         ST_DRAIN: begin
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (aligned || timeout) state_d = ST_DONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         isa_cnt_q   <= '0;
         drain_cnt_q <= '0;
         isa_step_q  <= 1'b0;
         deviation_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         isa_cnt_q   <= isa_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         isa_step_q  <= isa_step_d;
         deviation_q <= deviation_d;
      end
   end

   // MAX_SKEW >= 1 keeps the two stall conditions disjoint.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(stall1_c && stall2_c));
      end
   end

   assign stall1    = stall1_c;
   assign stall2    = stall2_c;
   assign isa_step  = isa_step_q;
   assign state     = state_q;
   assign deviation = deviation_q;
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_commit_sync_ctrl.sv
// Directed + randomized bench for commit_sync_ctrl against an unbounded-integer reference model.
module tb_commit_sync_ctrl;

   localparam int CNT_W     = 8;
   localparam int MAX_SKEW  = 4;
   localparam int DRAIN_TMO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, commit1 = 1'b0, commit2 = 1'b0, drain_req = 1'b0;
   logic       stall1, stall2, isa_step, deviation, done;
   logic [1:0] state;

   commit_sync_ctrl #(
      .CNT_W(CNT_W), .MAX_SKEW(MAX_SKEW), .DRAIN_TMO(DRAIN_TMO)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .commit1(commit1), .commit2(commit2),
      .drain_req(drain_req), .stall1(stall1), .stall2(stall2), .isa_step(isa_step),
      .state(state), .deviation(deviation), .done(done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: plain integers that never wrap; state 0..3 as in the FSM table.
   int m_st = 0, m_c1 = 0, m_c2 = 0, m_isa = 0, m_dcyc = 0;
   bit m_step = 1'b0, m_dev = 1'b0;

   int pulses = 0;
   bit stall_seen = 1'b0;
   bit ra, rb, rd;
   int n;

   function automatic bit m_stall1();
      int sk = m_c1 - m_c2;
      return (m_st == 1 && sk >= MAX_SKEW) || (m_st == 2 && sk > 0);
   endfunction

   function automatic bit m_stall2();
      int sk = m_c2 - m_c1;
      return (m_st == 1 && sk >= MAX_SKEW) || (m_st == 2 && sk > 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      chk("state",     32'(state),     32'(m_st));
      chk("stall1",    32'(stall1),    32'(m_stall1()));
      chk("stall2",    32'(stall2),    32'(m_stall2()));
      chk("isa_step",  32'(isa_step),  32'(m_step));
      chk("deviation", 32'(deviation), 32'(m_dev));
      chk("done",      32'(done),      32'(m_st == 3));
      if (isa_step === 1'b1) pulses++;
      if (stall1 === 1'b1 || stall2 === 1'b1) stall_seen = 1'b1;
   endtask

   task automatic model_adv();
      int sk, mn;
      bit s1, s2, act, aligned;
      if (rst) begin
         m_st = 0; m_c1 = 0; m_c2 = 0; m_isa = 0; m_dcyc = 0; m_step = 0; m_dev = 0;
         return;
      end
      sk      = m_c1 - m_c2;
      s1      = m_stall1();
      s2      = m_stall2();
      act     = (m_st == 1) || (m_st == 2);
      aligned = (m_c1 == m_c2) && (m_c2 == m_isa);
      mn      = (m_c1 < m_c2) ? m_c1 : m_c2;
      if ((commit1 && s1) || (commit2 && s2) || sk > MAX_SKEW || -sk > MAX_SKEW) m_dev = 1;
      case (m_st)
         0: if (en) m_st = 1;
         1: if (drain_req) m_st = 2;
         2: begin
            m_dcyc++;
            if (aligned) m_st = 3;
            else if (m_dcyc == DRAIN_TMO) begin m_st = 3; m_dev = 1; end
         end
         default: ;
      endcase
      if (mn > m_isa) begin m_step = 1; m_isa++; end
      else m_step = 0;
      if (act) begin
         m_c1 += int'(commit1);
         m_c2 += int'(commit2);
      end
   endtask

   // One clock cycle: drive, compare at negedge, advance model, return at posedge+1.
   task automatic cyc(input bit r, input bit e, input bit a, input bit b, input bit d);
      rst = r; en = e; commit1 = a; commit2 = b; drain_req = d;
      @(negedge clk);
      check_outputs();
      model_adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      cyc(1, 0, 0, 0, 0);
      chk("rst_state", 32'(state), 0);
      chk("rst_done", 32'(done), 0);

      // Commits before start are ignored.
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("run_entered", 32'(state), 1);

      // Joint commits: no stall, ten ISA steps lagging one cycle.
      pulses = 0; stall_seen = 0;
      repeat (10) cyc(0, 0, 1, 1, 0);
      repeat (3)  cyc(0, 0, 0, 0, 0);
      chk("joint_pulses", 32'(pulses), 10);
      chk("joint_nostall", 32'(stall_seen), 0);

      // Copy 1 runs ahead by MAX_SKEW, then copy 2 closes the gap by one.
      repeat (4) cyc(0, 0, 1, 0, 0);
      chk("skew4_stall1", 32'(stall1), 1);
      cyc(0, 0, 0, 1, 0);
      chk("skew3_stall1", 32'(stall1), 0);

      // Random commits that respect the stalls.
      for (int i = 0; i < 200; i++) begin
         ra = $urandom_range(0, 1) == 1 && !m_stall1();
         rb = $urandom_range(0, 1) == 1 && !m_stall2();
         cyc(0, 0, ra, rb, 0);
      end
      chk("rand_nodev", 32'(deviation), 0);

      // Reset while draining.
      while (m_c1 - m_c2 < 1) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("in_drain", 32'(state), 2);
      cyc(1, 0, 1, 1, 0);
      chk("mid_rst_state", 32'(state), 0);
      chk("mid_rst_stall1", 32'(stall1), 0);
      chk("mid_rst_stall2", 32'(stall2), 0);
      chk("mid_rst_step", 32'(isa_step), 0);
      chk("mid_rst_dev", 32'(deviation), 0);
      chk("mid_rst_done", 32'(done), 0);

      // Wrap-around: 254 joint commits then 4 more.
      cyc(0, 1, 0, 0, 0);
      repeat (254) cyc(0, 0, 1, 1, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      stall_seen = 0;
      repeat (4) cyc(0, 0, 1, 1, 0);
      repeat (2) cyc(0, 0, 0, 0, 0);
      chk("wrap_nostall", 32'(stall_seen), 0);
      chk("wrap_nodev", 32'(deviation), 0);

      // Drain with copy 1 two ahead; copy 2 catches up.
      repeat (2) cyc(0, 0, 1, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("drain_stall1", 32'(stall1), 1);
      repeat (2) cyc(0, 0, 0, 1, 0);
      n = 0;
      while (state !== 2'd3 && n < 10) begin cyc(0, 0, 0, 0, 0); n++; end
      chk("drain_done", 32'(done), 1);
      chk("drain_nodev", 32'(deviation), 0);
      cyc(0, 1, 1, 1, 1);
      chk("done_terminal", 32'(state), 3);

      // Ignored stall, then drain timeout.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      repeat (4) cyc(0, 0, 1, 0, 0);
      chk("viol_stall1", 32'(stall1), 1);
      cyc(0, 0, 1, 0, 0);
      chk("viol_dev", 32'(deviation), 1);
      cyc(0, 0, 0, 0, 1);
      n = 0;
      while (state === 2'd2 && n < 40) begin cyc(0, 0, 0, 0, 0); n++; end
      chk("tmo_cycles", 32'(n), 16);
      chk("tmo_done", 32'(done), 1);
      repeat (3) cyc(0, 0, 1, 0, 0);
      chk("tmo_dev_sticky", 32'(deviation), 1);

      // Random run with occasional stall violations and a random drain.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 300 && m_st != 3; i++) begin
         ra = $urandom_range(0, 1) == 1;
         rb = $urandom_range(0, 1) == 1;
         if (m_stall1() && $urandom_range(0, 9) != 0) ra = 0;
         if (m_stall2() && $urandom_range(0, 9) != 0) rb = 0;
         rd = (i > 100) && ($urandom_range(0, 29) == 0);
         cyc(0, 0, ra, rb, rd);
      end
      repeat (20) cyc(0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
